// File: rtl/riscv_hpc_sampler.sv
// Periodic sampler of the R/I/S/B/U/J instruction counters.
// Streams six per-interval deltas as valid/ready words.
module riscv_hpc_sampler #(
  parameter int INTERVAL_W = 16,
  parameter int SEQ_W      = 8,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [INTERVAL_W-1:0] cfg_interval_i,
  input  logic [31:0]           cnt_rtype_i,
  input  logic [31:0]           cnt_itype_i,
  input  logic [31:0]           cnt_stype_i,
  input  logic [31:0]           cnt_btype_i,
  input  logic [31:0]           cnt_utype_i,
  input  logic [31:0]           cnt_jtype_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [31:0]           rec_data_o,
  output logic [2:0]            rec_idx_o,
  output logic                  rec_last_o,
  output logic [SEQ_W-1:0]      rec_seq_o,
  output logic [DROP_W-1:0]     drop_cnt_o,
  output logic                  busy_o
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SEND   = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'd5;

  logic [31:0]           cnt     [6];
  logic [31:0]           base_q  [6];
  logic [31:0]           base_d  [6];
  logic [31:0]           delta_q [6];
  logic [31:0]           delta_d [6];
  logic                  en_q, en_d;
  logic [INTERVAL_W-1:0] timer_q, timer_d;
  logic [0:0]            state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic [INTERVAL_W-1:0] lim_m1;
  logic                  en_rise;
  logic                  tick;
  logic                  hs;
  logic                  fin;
  logic                  free;

  assign cnt[0] = cnt_rtype_i;
  assign cnt[1] = cnt_itype_i;
  assign cnt[2] = cnt_stype_i;
  assign cnt[3] = cnt_btype_i;
  assign cnt[4] = cnt_utype_i;
  assign cnt[5] = cnt_jtype_i;

  // Interval timer; the enable edge only re-baselines, never ticks
  always_comb begin
    lim_m1 = (cfg_interval_i == '0) ? '0
           : cfg_interval_i - INTERVAL_W'(1);
    en_rise = enable_i & ~en_q;
    tick    = enable_i & ~en_rise & (timer_q == lim_m1);
    en_d    = enable_i;
    timer_d = '0;
    if (enable_i && (timer_q != lim_m1))
      timer_d = timer_q + INTERVAL_W'(1);
  end

  // Send engine, snapshot and drop accounting
  always_comb begin
    hs      = (state_q == S_SEND) & rec_ready_i;
    fin     = hs & (idx_q == LAST_IDX);
    free    = (state_q == S_IDLE) | fin;
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    base_d  = base_q;
    delta_d = delta_q;
    if (hs)
      idx_d = idx_q + 3'd1;
    if (fin) begin
      state_d = S_IDLE;
      idx_d   = '0;
      seq_d   = seq_q + SEQ_W'(1);
    end
    if (en_rise)
      base_d = cnt;
    if (tick) begin
      if (free) begin
        for (int i = 0; i < 6; i++) begin
          delta_d[i] = cnt[i] - base_q[i];
          base_d[i]  = cnt[i];
        end
        state_d = S_SEND;
        idx_d   = '0;
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      timer_q <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < 6; i++) begin
        base_q[i]  <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      en_q    <= en_d;
      timer_q <= timer_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      for (int i = 0; i < 6; i++) begin
        base_q[i]  <= base_d[i];
        delta_q[i] <= delta_d[i];
      end
    end
  end

  // Word select for the current record index
  always_comb begin
    rec_data_o = '0;
    case (idx_q)
      3'd0:    rec_data_o = delta_q[0];
      3'd1:    rec_data_o = delta_q[1];
      3'd2:    rec_data_o = delta_q[2];
      3'd3:    rec_data_o = delta_q[3];
      3'd4:    rec_data_o = delta_q[4];
      3'd5:    rec_data_o = delta_q[5];
      default: rec_data_o = '0;
    endcase
  end

  assign rec_valid_o = (state_q == S_SEND);
  assign busy_o      = (state_q == S_SEND);
  assign rec_last_o  = (state_q == S_SEND) & (idx_q == LAST_IDX);
  assign rec_idx_o   = idx_q;
  assign rec_seq_o   = seq_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_riscv_hpc_sampler.sv
// Self-checking bench for riscv_hpc_sampler.
// Transaction-level model: ticks from enabled-cycle count, records as a word queue.
module tb_riscv_hpc_sampler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [15:0] cfg_interval_i;
  logic        rec_ready_i;
  logic [31:0] c [6];
  logic        rec_valid_o;
  logic [31:0] rec_data_o;
  logic [2:0]  rec_idx_o;
  logic        rec_last_o;
  logic [7:0]  rec_seq_o;
  logic [7:0]  drop_cnt_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_hpc_sampler dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .cfg_interval_i (cfg_interval_i),
    .cnt_rtype_i    (c[0]),
    .cnt_itype_i    (c[1]),
    .cnt_stype_i    (c[2]),
    .cnt_btype_i    (c[3]),
    .cnt_utype_i    (c[4]),
    .cnt_jtype_i    (c[5]),
    .rec_valid_o    (rec_valid_o),
    .rec_ready_i    (rec_ready_i),
    .rec_data_o     (rec_data_o),
    .rec_idx_o      (rec_idx_o),
    .rec_last_o     (rec_last_o),
    .rec_seq_o      (rec_seq_o),
    .drop_cnt_o     (drop_cnt_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
    int          seq;
  } word_t;

  word_t       q[$];
  logic [31:0] m_base [6];
  int          m_seq;
  int          m_drop;
  int          m_k;
  bit          m_en;

  function automatic void model_reset();
    q.delete();
    m_seq  = 0;
    m_drop = 0;
    m_k    = 0;
    m_en   = 0;
    for (int i = 0; i < 6; i++) m_base[i] = '0;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled
  function automatic void model_update();
    int    lim;
    word_t w;
    if (rst_i) begin
      model_reset();
      return;
    end
    lim = (cfg_interval_i == 0) ? 1 : int'(cfg_interval_i);
    if (q.size() > 0 && rec_ready_i) begin
      w = q.pop_front();
      if (w.idx == 5) m_seq = (m_seq + 1) % 256;
    end
    if (enable_i && !m_en) begin
      for (int i = 0; i < 6; i++) m_base[i] = c[i];
      m_k = 0;
    end else if (enable_i) begin
      m_k++;
      if (m_k % lim == lim - 1) begin
        if (q.size() == 0) begin
          for (int i = 0; i < 6; i++) begin
            w.data = c[i] - m_base[i];
            w.idx  = i;
            w.seq  = m_seq;
            q.push_back(w);
            m_base[i] = c[i];
          end
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    m_en = enable_i;
  endfunction

  // Compare outputs with the model, then advance one cycle (negedge to negedge)
  task automatic clk_step();
    bit ev;
    int es;
    ev = (q.size() > 0);
    es = ev ? q[0].seq : m_seq;
    checks++;
    if (rec_valid_o !== ev) begin
      failures++;
      $display("FAIL valid got=%0b exp=%0b t=%0t", rec_valid_o, ev, $time);
    end
    checks++;
    if (busy_o !== ev) begin
      failures++;
      $display("FAIL busy got=%0b exp=%0b t=%0t", busy_o, ev, $time);
    end
    checks++;
    if (drop_cnt_o !== 8'(m_drop)) begin
      failures++;
      $display("FAIL drop got=%0d exp=%0d t=%0t", drop_cnt_o, m_drop, $time);
    end
    checks++;
    if (rec_seq_o !== 8'(es)) begin
      failures++;
      $display("FAIL seq got=%0d exp=%0d t=%0t", rec_seq_o, es, $time);
    end
    checks++;
    if (rec_last_o !== (ev && q[0].idx == 5)) begin
      failures++;
      $display("FAIL last got=%0b t=%0t", rec_last_o, $time);
    end
    if (ev) begin
      checks++;
      if (rec_idx_o !== 3'(q[0].idx)) begin
        failures++;
        $display("FAIL idx got=%0d exp=%0d t=%0t", rec_idx_o, q[0].idx, $time);
      end
      checks++;
      if (rec_data_o !== q[0].data) begin
        failures++;
        $display("FAIL data got=%0h exp=%0h t=%0t", rec_data_o, q[0].data, $time);
      end
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    enable_i    = 1'b0;
    rec_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic bump();
    for (int i = 0; i < 6; i++) c[i] = c[i] + $urandom_range(0, 3);
  endtask

  task automatic test_reset();
    cfg_interval_i = 16'd4;
    for (int i = 0; i < 6; i++) c[i] = $urandom;
    do_reset();
    checks++;
    if ({rec_valid_o, busy_o, rec_last_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {rec_valid_o, busy_o, rec_last_o});
    end
    checks++;
    if (rec_data_o !== 32'd0 || rec_idx_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_word got=%0h/%0d exp=0/0", rec_data_o, rec_idx_o);
    end
    checks++;
    if (rec_seq_o !== 8'd0 || drop_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", rec_seq_o, drop_cnt_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [6];
    exp_w = '{32'd5, 32'd2, 32'd0, 32'd1, 32'd0, 32'd0};
    do_reset();
    cfg_interval_i = 16'd4;
    rec_ready_i = 1'b1;
    c = '{32'd10, 32'd20, 32'd0, 32'd3, 32'd0, 32'd1};
    enable_i = 1'b1;
    clk_step();
    c[0] = 32'd15;
    c[1] = 32'd22;
    c[3] = 32'd4;
    repeat (3) clk_step();
    enable_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rec_valid_o !== 1'b1 || rec_idx_o !== 3'(i) || rec_data_o !== exp_w[i]
          || rec_last_o !== (i == 5) || rec_seq_o !== 8'd0) begin
        failures++;
        $display("FAIL basic_w%0d got v=%0b idx=%0d d=%0d l=%0b s=%0d exp d=%0d",
                 i, rec_valid_o, rec_idx_o, rec_data_o, rec_last_o, rec_seq_o, exp_w[i]);
      end
      clk_step();
    end
    checks++;
    if (rec_valid_o !== 1'b0 || rec_seq_o !== 8'd1 || drop_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL basic_end got v=%0b s=%0d dr=%0d exp 0/1/0",
               rec_valid_o, rec_seq_o, drop_cnt_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cfg_interval_i = 16'd2;
    rec_ready_i = 1'b1;
    c[0] = 32'hFFFF_FFFE;
    enable_i = 1'b1;
    clk_step();
    c[0] = 32'h0000_0003;
    clk_step();
    checks++;
    if (rec_valid_o !== 1'b1 || rec_idx_o !== 3'd0 || rec_data_o !== 32'd5) begin
      failures++;
      $display("FAIL wrap got v=%0b idx=%0d d=%0h exp 1/0/5",
               rec_valid_o, rec_idx_o, rec_data_o);
    end
    enable_i = 1'b0;
    repeat (7) clk_step();
  endtask

  task automatic test_backpressure();
    logic [31:0] r0, r1;
    bit          seen;
    do_reset();
    cfg_interval_i = 16'd4;
    rec_ready_i = 1'b0;
    enable_i = 1'b1;
    r0 = c[0];
    r1 = c[0];
    for (int j = 0; j < 4; j++) begin
      if (j > 0) bump();
      if (j == 0) r0 = c[0];
      if (j == 3) r1 = c[0];
      clk_step();
    end
    repeat (20) begin
      bump();
      clk_step();
    end
    checks++;
    if (drop_cnt_o !== 8'd5 || rec_valid_o !== 1'b1 || rec_idx_o !== 3'd0
        || rec_data_o !== r1 - r0) begin
      failures++;
      $display("FAIL bp_hold got dr=%0d v=%0b idx=%0d d=%0h exp 5/1/0/%0h",
               drop_cnt_o, rec_valid_o, rec_idx_o, rec_data_o, r1 - r0);
    end
    rec_ready_i = 1'b1;
    repeat (6) clk_step();
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      if (rec_valid_o === 1'b1) seen = 1;
      else clk_step();
    end
    checks++;
    if (!seen || rec_data_o !== c[0] - r1) begin
      failures++;
      $display("FAIL bp_merge got seen=%0b d=%0h exp %0h", seen, rec_data_o, c[0] - r1);
    end
    enable_i = 1'b0;
    repeat (8) clk_step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_interval_i = 16'd6;
    rec_ready_i = 1'b1;
    enable_i = 1'b1;
    repeat (6) begin
      bump();
      clk_step();
    end
    for (int j = 0; j < 24; j++) begin
      checks++;
      if (rec_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid cyc=%0d got=%0b exp=1", j, rec_valid_o);
      end
      bump();
      clk_step();
    end
    checks++;
    if (rec_seq_o !== 8'd4 || rec_idx_o !== 3'd0 || drop_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL b2b_end got s=%0d idx=%0d dr=%0d exp 4/0/0",
               rec_seq_o, rec_idx_o, drop_cnt_o);
    end
    enable_i = 1'b0;
    repeat (7) clk_step();
  endtask

  task automatic test_interval0();
    do_reset();
    cfg_interval_i = 16'd0;
    rec_ready_i = 1'b1;
    enable_i = 1'b1;
    repeat (8) begin
      bump();
      clk_step();
    end
    checks++;
    if (drop_cnt_o !== 8'd5 || rec_seq_o !== 8'd1) begin
      failures++;
      $display("FAIL int0_first got dr=%0d s=%0d exp 5/1", drop_cnt_o, rec_seq_o);
    end
    repeat (330) begin
      bump();
      clk_step();
    end
    checks++;
    if (drop_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL int0_sat got=%0d exp=255", drop_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    do_reset();
    cfg_interval_i = 16'd3;
    rec_ready_i = 1'b1;
    enable_i = 1'b1;
    hit = 0;
    for (int j = 0; j < 40 && !hit; j++) begin
      if (rec_valid_o === 1'b1 && rec_idx_o === 3'd3) hit = 1;
      else begin
        bump();
        clk_step();
      end
    end
    checks++;
    if (!hit || drop_cnt_o === 8'd0) begin
      failures++;
      $display("FAIL rstmid_reach got hit=%0b dr=%0d exp hit=1 dr>0", hit, drop_cnt_o);
    end
    rst_i = 1'b1;
    clk_step();
    rst_i = 1'b0;
    checks++;
    if (rec_valid_o !== 1'b0 || drop_cnt_o !== 8'd0 || rec_seq_o !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_clr got v=%0b dr=%0d s=%0d exp 0/0/0",
               rec_valid_o, drop_cnt_o, rec_seq_o);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rec_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_quiet cyc=%0d got=%0b exp=0", j, rec_valid_o);
      end
      clk_step();
    end
    checks++;
    if (rec_valid_o !== 1'b1 || rec_idx_o !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_restart got v=%0b idx=%0d exp 1/0", rec_valid_o, rec_idx_o);
    end
    enable_i = 1'b0;
    repeat (8) clk_step();
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 1500; j++) begin
      bump();
      if ($urandom_range(0, 49) == 0) c[$urandom_range(0, 5)] = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        if (!enable_i) cfg_interval_i = 16'($urandom_range(0, 7));
        enable_i = ~enable_i;
      end
      rec_ready_i = ($urandom_range(0, 3) != 0);
      clk_step();
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    enable_i       = 1'b0;
    rec_ready_i    = 1'b0;
    cfg_interval_i = 16'd0;
    for (int i = 0; i < 6; i++) c[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_interval0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
